// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, funct3
// values, forward-select encodings, decode/stage structs and the forward
// select helper.
package pipe_hazard_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SRAI = 3'b101;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Register usage of one decoded instruction.
    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses1;
        logic       uses2;
        logic       wr;
        logic       ld;
    } instr_class_t;

    // Shadow copy of what a pipeline stage holds; all-zero is a bubble.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses1;
        logic       uses2;
        logic       wr;
        logic       ld;
    } stage_t;

    // Pick the forwarding source for one EX operand; the younger MEM result
    // wins over WB, and x0 is never forwarded.
    function automatic logic [1:0] fwdSel(input stage_t memQ, input stage_t wbQ,
                                          input logic uses, input logic [4:0] rs);
        logic [1:0] sel;
        sel = FWD_RF;
        if (uses && memQ.wr && (memQ.rd != 5'd0) && (memQ.rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (uses && wbQ.wr && (wbQ.rd != 5'd0) && (wbQ.rd == rs)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_instr_class.sv
// Combinational decode of an IF/ID instruction into its register usage.
// Encodings outside the supported subset decode with every flag cleared.
module pipe_instr_class
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [31:0]  i_instr,
    output instr_class_t o_class
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    // Classify the opcode/funct fields and attach the register indices.
    always_comb begin
        o_class       = '0;
        o_class.rd    = i_instr[11:7];
        o_class.rs1   = i_instr[19:15];
        o_class.rs2   = i_instr[24:20];
        unique case (w_opcode)
            OP_R: begin
                if ((w_funct7 == F7_BASE) || (w_funct7 == F7_ALT)) begin
                    o_class.uses1 = 1'b1;
                    o_class.uses2 = 1'b1;
                    o_class.wr    = 1'b1;
                end
            end
            OP_IMM: begin
                if ((w_funct3 == F3_ADDI) ||
                    ((w_funct3 == F3_SRAI) && (w_funct7 == F7_ALT))) begin
                    o_class.uses1 = 1'b1;
                    o_class.wr    = 1'b1;
                end
            end
            OP_LD: begin
                if (w_funct3 == F3_LW) begin
                    o_class.uses1 = 1'b1;
                    o_class.wr    = 1'b1;
                    o_class.ld    = 1'b1;
                end
            end
            OP_ST: begin
                if (w_funct3 == F3_SW) begin
                    o_class.uses1 = 1'b1;
                    o_class.uses2 = 1'b1;
                end
            end
            OP_BR: begin
                if (w_funct3 == F3_BEQ) begin
                    o_class.uses1 = 1'b1;
                    o_class.uses2 = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: boot hold-off, load-use stall, branch flush
// and EX-stage forwarding, driven from shadow copies of EX/MEM/WB.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      instr_i,
    input  logic             branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic [1:0]       forward_a_o,
    output logic [1:0]       forward_b_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_bootCnt;
    stage_t           r_exQ;
    stage_t           r_memQ;
    stage_t           r_wbQ;
    logic [CNT_W-1:0] r_stallCnt;

    instr_class_t     w_dec;
    stage_t           w_decStage;
    logic             w_loadUse;
    logic             w_unusedBits;

    pipe_instr_class u_class (
        .i_instr (instr_i),
        .o_class (w_dec)
    );

    assign w_decStage = '{valid: w_dec.uses1, rd: w_dec.rd, rs1: w_dec.rs1,
                          rs2: w_dec.rs2, uses1: w_dec.uses1, uses2: w_dec.uses2,
                          wr: w_dec.wr, ld: w_dec.ld};

    // The instruction in ID needs a value that the load in EX has not fetched yet.
    assign w_loadUse = r_exQ.ld && (r_exQ.rd != 5'd0) &&
                       ((w_dec.uses1 && (w_dec.rs1 == r_exQ.rd)) ||
                        (w_dec.uses2 && (w_dec.rs2 == r_exQ.rd)));

    // Fields that the control logic never looks at, gathered in one place.
    assign w_unusedBits = ^{r_exQ.valid, r_memQ, r_wbQ};

    // Boot/run sequencing, stage shadow pipeline and stall counting.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_BOOT;
            r_bootCnt  <= 4'd0;
            r_exQ      <= '0;
            r_memQ     <= '0;
            r_wbQ      <= '0;
            r_stallCnt <= '0;
        end else begin
            unique case (r_state)
                ST_BOOT: begin
                    if (r_bootCnt == BOOT_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_bootCnt <= r_bootCnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    r_exQ  <= idex_flush_o ? '0 : w_decStage;
                    r_memQ <= r_exQ;
                    r_wbQ  <= r_memQ;
                    if (w_loadUse && !branch_taken_i && (r_stallCnt != {CNT_W{1'b1}})) begin
                        r_stallCnt <= r_stallCnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    // Same-cycle pipeline control: branch flush beats load-use stall.
    always_comb begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
        forward_a_o  = FWD_RF;
        forward_b_o  = FWD_RF;
        if (r_state == ST_RUN) begin
            forward_a_o = fwdSel(r_memQ, r_wbQ, r_exQ.uses1, r_exQ.rs1);
            forward_b_o = fwdSel(r_memQ, r_wbQ, r_exQ.uses2, r_exQ.rs2);
            if (branch_taken_i) begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (w_loadUse) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                ifid_flush_o = 1'b0;
                idex_flush_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = 1'b0;
                idex_flush_o = 1'b0;
            end
        end
    end

    assign stall_cnt_o = r_stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-encoded instruction sequences
// with hand-computed control, forward and stall-count expectations.
module tb_pipe_hazard_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        branch_taken_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic        idex_flush_o;
    logic [1:0]  forward_a_o;
    logic [1:0]  forward_b_o;
    logic [15:0] stall_cnt_o;

    int vectors;
    int miscompares;

    // Control expectation patterns: {pc_w, ifid_w, ifid_flush, idex_flush, fa, fb}
    localparam logic [7:0] C_BOOT   = 8'b0011_0000;
    localparam logic [7:0] C_RUN    = 8'b1100_0000;
    localparam logic [7:0] C_STALL  = 8'b0001_0000;
    localparam logic [7:0] C_BRANCH = 8'b1111_0000;

    localparam logic [31:0] NOP = 32'h0000_0013;

    pipe_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_i        (instr_i),
        .branch_taken_i (branch_taken_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_flush_o   (idex_flush_o),
        .forward_a_o    (forward_a_o),
        .forward_b_o    (forward_b_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] encR(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] encAddi(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] encLw(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] encSw(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    // Present one ID-stage instruction in the low clock phase and let it settle.
    task automatic applyStimulus(input logic [31:0] instr, input logic br);
        @(negedge clk_i);
        instr_i        = instr;
        branch_taken_i = br;
        #1;
    endtask

    // Compare the control/forward bundle and the stall counter.
    task automatic checkOutput(input string tag, input logic [7:0] expCtl,
                               input logic [15:0] expStall);
        logic [7:0] obsCtl;
        obsCtl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
                  forward_a_o, forward_b_o};
        vectors++;
        assert (obsCtl === expCtl) else begin
            miscompares++;
            $error("[TB] FAIL %s ctl: observed %b expected %b", tag, obsCtl, expCtl);
        end
        vectors++;
        assert (stall_cnt_o === expStall) else begin
            miscompares++;
            $error("[TB] FAIL %s stall: observed %0d expected %0d", tag, stall_cnt_o, expStall);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_i          = 1'b0;
        instr_i        = NOP;
        branch_taken_i = 1'b0;

        applyStimulus(NOP, 1'b0);
        checkOutput("reset", C_BOOT, 16'd0);

        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("boot1", C_BOOT, 16'd0);
        applyStimulus(NOP, 1'b1);
        checkOutput("boot2_br_ignored", C_BOOT, 16'd0);

        applyStimulus(encLw(5'd5, 5'd1, 12'd0), 1'b0);
        checkOutput("run_first_lw", C_RUN, 16'd0);
        applyStimulus(encR(5'd6, 5'd5, 5'd2), 1'b0);
        checkOutput("loaduse_stall", C_STALL, 16'd0);
        applyStimulus(encR(5'd6, 5'd5, 5'd2), 1'b0);
        checkOutput("after_stall", C_RUN, 16'd1);
        applyStimulus(NOP, 1'b0);
        checkOutput("lw_fwd_a_wb", 8'b1100_0100, 16'd1);

        applyStimulus(encAddi(5'd3, 5'd0, 12'd7), 1'b0);
        checkOutput("addi_x3", C_RUN, 16'd1);
        applyStimulus(encSw(5'd3, 5'd4, 12'd4), 1'b0);
        checkOutput("sw_in_id", C_RUN, 16'd1);
        applyStimulus(NOP, 1'b0);
        checkOutput("sw_fwd_b_mem", 8'b1100_0010, 16'd1);

        applyStimulus(encAddi(5'd7, 5'd0, 12'd1), 1'b0);
        checkOutput("addi_x7_a", C_RUN, 16'd1);
        applyStimulus(encAddi(5'd7, 5'd0, 12'd2), 1'b0);
        checkOutput("addi_x7_b", C_RUN, 16'd1);
        applyStimulus(encR(5'd8, 5'd7, 5'd0), 1'b0);
        checkOutput("add_x8", C_RUN, 16'd1);
        applyStimulus(NOP, 1'b0);
        checkOutput("mem_over_wb", 8'b1100_1000, 16'd1);
        applyStimulus(encR(5'd9, 5'd0, 5'd8), 1'b0);
        checkOutput("add_x9", C_RUN, 16'd1);
        applyStimulus(NOP, 1'b0);
        checkOutput("fwd_b_wb", 8'b1100_0001, 16'd1);

        applyStimulus(encLw(5'd0, 5'd1, 12'd0), 1'b0);
        checkOutput("lw_x0", C_RUN, 16'd1);
        applyStimulus(encR(5'd10, 5'd0, 5'd0), 1'b0);
        checkOutput("x0_no_stall", C_RUN, 16'd1);
        applyStimulus(NOP, 1'b0);
        checkOutput("x0_no_fwd", C_RUN, 16'd1);

        applyStimulus(encLw(5'd5, 5'd1, 12'd0), 1'b0);
        checkOutput("lw_before_branch", C_RUN, 16'd1);
        applyStimulus(encR(5'd6, 5'd5, 5'd2), 1'b1);
        checkOutput("branch_over_stall", C_BRANCH, 16'd1);
        applyStimulus(NOP, 1'b0);
        checkOutput("branch_no_count", C_RUN, 16'd1);

        applyStimulus(encLw(5'd5, 5'd1, 12'd0), 1'b0);
        checkOutput("lw_before_reset", C_RUN, 16'd1);
        applyStimulus(encR(5'd6, 5'd5, 5'd2), 1'b0);
        checkOutput("stall_before_reset", C_STALL, 16'd1);
        rst_i = 1'b0;
        #1;
        checkOutput("async_reset", C_BOOT, 16'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("reboot1", C_BOOT, 16'd0);
        applyStimulus(encR(5'd6, 5'd5, 5'd2), 1'b0);
        checkOutput("reboot2", C_BOOT, 16'd0);
        applyStimulus(encR(5'd6, 5'd5, 5'd2), 1'b0);
        checkOutput("shadow_cleared", C_RUN, 16'd0);
        applyStimulus(NOP, 1'b0);
        checkOutput("no_stale_fwd", C_RUN, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
